instr_prefetch: RTL and testbench
=================================

# instr_prefetch

Instruction prefetch buffer between the instruction ROM and the control state machine. It drives ROM addresses from its own fetch PC and captures each 16-bit instruction together with its PC into a small FIFO. The control unit pops decoded-ready instructions through a valid/ready handshake. Jumps, taken compare-jumps and halt are fed back as redirect and halt requests.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- AW, 8: PC/ROM address width.
- DW, 16: instruction width.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately while low.
- rom_addr  out  AW  ROM address; combinational copy of fetch_pc.
- rom_data  in  DW  ROM read data; combinational, valid in the same cycle as rom_addr.
- redirect  in  1  flush-and-restart request; sampled at the rising edge.
- redirect_pc  in  AW  new fetch address, used when redirect=1.
- halt  in  1  level signal; while high, no new fetches are made.
- instr_valid  out  1  FIFO head is valid.
- instr_data  out  DW  head instruction; 0 when instr_valid=0.
- instr_pc  out  AW  PC of the head instruction; 0 when instr_valid=0.
- instr_ready  in  1  consumer accepts the head.
- count  out  $clog2(DEPTH)+1  current occupancy.
- fetch_pc  out  AW  next address to fetch.

## Operation
- Storage is a circular FIFO of {pc, instr} entries, with rd_ptr, wr_ptr and count registers.
- pop = instr_valid & instr_ready & ~redirect.
- push = ~redirect & ~halt & (count<DEPTH | pop).
  - Simultaneous push and pop while full is legal; count holds at DEPTH.
- On push:
  - the entry {fetch_pc, rom_data} is written at wr_ptr;
  - wr_ptr advances;
  - fetch_pc advances by 1 modulo 2^AW, so 8'hFF wraps to 8'h00.
- Count update:
  - push only: +1;
  - pop only: -1;
  - both or neither: unchanged.
- When fetch is stalled (full without pop, or halt), fetch_pc and rom_addr hold.
- Redirect has the highest priority. On redirect:
  - count=0 and rd_ptr=wr_ptr=0;
  - fetch_pc <= redirect_pc;
  - no push or pop happens that cycle; the head presented that cycle is discarded even if instr_ready=1.
- Redirect with halt=1: the flush and fetch_pc load still occur; fetching stays suppressed until halt falls.
- Halt only gates pushes; the FIFO continues to drain to the consumer.
- FSM, for status only: RUN (halt=0) and HALTED (halt=1). Transitions follow halt at each edge; there is no other effect.
- Reset values: fetch_pc=0, rom_addr=0, count=0, pointers=0, instr_valid=0, instr_data=0, instr_pc=0. Storage contents are don't-care.

## Timing
- Fetch-to-available latency is 1 cycle. The instruction at rom_addr is pushed at edge N and shows instr_valid=1 after edge N.
- After reset rises, the first edge pushes PC 0.
- With instr_ready held high, the sustained throughput is 1 instruction per cycle.
- instr_valid, instr_data and instr_pc are combinational from registered FIFO state only. They never depend combinationally on instr_ready, redirect or halt.
- Redirect asserted during cycle N:
  - after edge N: instr_valid=0, fetch_pc=redirect_pc;
  - after edge N+1: head = redirect_pc instruction.
- Reset asserted mid-operation: all outputs go to reset values without waiting for a clock edge.

## Test plan
- Streaming:
  - stimulus: ROM returns 16'hA000+addr, instr_ready=1 after reset;
  - response: instr_pc = 0,1,2,3… on consecutive cycles, instr_data=16'hA000+instr_pc, count stays 1.
- Backpressure:
  - stimulus: instr_ready=0 from reset;
  - response: count reaches 4 after 4 edges, fetch_pc=4 and held.
  - Then instr_ready=1 for one cycle: head pc 0 popped, pc 4 pushed at the same edge, count=4, fetch_pc=5.
- Redirect flush:
  - stimulus: with 3 entries queued, redirect=1, redirect_pc=8'h40, instr_ready=1 for one cycle;
  - response: next cycle instr_valid=0, count=0; following cycle instr_pc=8'h40.
- Wrap-around:
  - stimulus: redirect_pc=8'hFE, instr_ready=1;
  - response: instr_pc sequence FE, FF, 00, 01.
- Halt drain:
  - stimulus: halt=1 with 2 entries and instr_ready=1;
  - response: 2 pops, then instr_valid=0 and fetch_pc frozen.
  - Then halt=0: fetching resumes at the frozen fetch_pc.
  - Also: redirect during halt loads fetch_pc without pushing.
- Async reset:
  - stimulus: reset low between edges with the FIFO full;
  - response: instr_valid=0, count=0, fetch_pc=0 immediately. After release, PC 0 is pushed on the first edge.

Source files
------------

// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer: fetches from ROM at its own PC into a small {pc, instr} FIFO
// and hands the head to the control unit over valid/ready; redirect flushes, halt stops fetching.
module instr_prefetch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [AW-1:0]            rom_addr,
  input  logic [DW-1:0]            rom_data,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  input  logic                     halt,
  output logic                     instr_valid,
  output logic [DW-1:0]            instr_data,
  output logic [AW-1:0]            instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [AW-1:0]            fetch_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = AW + DW;

  typedef enum logic {RUN, HALTED} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [EW-1:0]   mem [DEPTH];
  logic            push_c;
  logic            pop_c;

  // Head view depends only on registered FIFO state.
  assign instr_valid = (count != '0);
  assign instr_data  = instr_valid ? mem[rd_ptr][DW-1:0] : '0;
  assign instr_pc    = instr_valid ? mem[rd_ptr][EW-1:DW] : '0;
  assign rom_addr    = fetch_pc;

  assign pop_c  = instr_valid & instr_ready & ~redirect;
  assign push_c = ~redirect & ~halt & ((count < CW'(DEPTH)) | pop_c);

  // Status-only run/halt tracker.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt)  state_d = HALTED;
      HALTED:  if (!halt) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Pointers, occupancy and fetch PC; redirect overrides everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= '0;
    end else if (redirect) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= redirect_pc;
    end else begin
      if (push_c) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      if (push_c && !pop_c)      count <= count + CW'(1);
      else if (pop_c && !push_c) count <= count - CW'(1);
    end
  end

  // Entry storage carries no reset; only slots below count are ever observed.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= {fetch_pc, rom_data};
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: a queue-based reference model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_instr_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          halt;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic [2:0]    count;
  logic [AW-1:0] fetch_pc;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] mq[$];
  logic [AW-1:0] m_fpc = '0;

  instr_prefetch #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .count(count), .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  assign rom_data = 16'hA000 + 16'(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue of PCs, updated from the inputs seen at each edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_fpc = '0;
    end else if (redirect) begin
      mq.delete();
      m_fpc = redirect_pc;
    end else begin
      automatic bit do_pop  = (mq.size() != 0) && instr_ready;
      automatic bit do_push = !halt && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(m_fpc);
        m_fpc = m_fpc + 8'd1;
      end
    end
  end

  // Every-cycle comparison against the model, just after the active edge.
  always @(posedge clk) begin
    #1;
    check("m_valid", 32'(instr_valid), 32'(mq.size() != 0));
    check("m_count", 32'(count), 32'(mq.size()));
    check("m_fetch_pc", 32'(fetch_pc), 32'(m_fpc));
    check("m_rom_addr", 32'(rom_addr), 32'(m_fpc));
    if (mq.size() != 0) begin
      check("m_instr_pc", 32'(instr_pc), 32'(mq[0]));
      check("m_instr_data", 32'(instr_data), 32'(16'hA000 + 16'(mq[0])));
    end else begin
      check("m_instr_pc_zero", 32'(instr_pc), 32'd0);
      check("m_instr_data_zero", 32'(instr_data), 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_head(input string name, input logic [AW-1:0] pc, input int cnt, input logic [AW-1:0] fpc);
    check({name, "_valid"}, 32'(instr_valid), 32'd1);
    check({name, "_pc"}, 32'(instr_pc), 32'(pc));
    check({name, "_data"}, 32'(instr_data), 32'(16'hA000 + 16'(pc)));
    check({name, "_count"}, 32'(count), 32'(cnt));
    check({name, "_fetch_pc"}, 32'(fetch_pc), 32'(fpc));
  endtask

  task automatic expect_empty(input string name, input logic [AW-1:0] fpc);
    check({name, "_valid"}, 32'(instr_valid), 32'd0);
    check({name, "_count"}, 32'(count), 32'd0);
    check({name, "_pc"}, 32'(instr_pc), 32'd0);
    check({name, "_fetch_pc"}, 32'(fetch_pc), 32'(fpc));
  endtask

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; instr_ready = 1'b1;
    cyc(1);
    expect_empty("reset", 8'h00);
    reset = 1'b1;

    // Streaming: one instruction per cycle, count stays 1.
    cyc(1);
    expect_head("stream0", 8'h00, 1, 8'h01);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      expect_head("stream", 8'(k), 1, 8'(k + 1));
    end

    // Backpressure from reset.
    instr_ready = 1'b0;
    reset = 1'b0;
    #1 expect_empty("rst2", 8'h00);
    cyc(1);
    reset = 1'b1;
    cyc(4);
    expect_head("bp_full", 8'h00, 4, 8'h04);
    cyc(2);
    expect_head("bp_hold", 8'h00, 4, 8'h04);
    instr_ready = 1'b1;
    cyc(1);
    expect_head("bp_popush", 8'h01, 4, 8'h05);

    // Drop to 3 entries, then redirect with ready high.
    halt = 1'b1;
    cyc(1);
    expect_head("three", 8'h02, 3, 8'h05);
    halt = 1'b0; redirect = 1'b1; redirect_pc = 8'h40;
    cyc(1);
    expect_empty("flush", 8'h40);
    redirect = 1'b0; instr_ready = 1'b0;
    cyc(1);
    expect_head("after_flush", 8'h40, 1, 8'h41);

    // Wrap-around of fetch PC.
    redirect = 1'b1; redirect_pc = 8'hFE; instr_ready = 1'b1;
    cyc(1);
    expect_empty("wrap_flush", 8'hFE);
    redirect = 1'b0;
    cyc(1); expect_head("wrap_fe", 8'hFE, 1, 8'hFF);
    cyc(1); expect_head("wrap_ff", 8'hFF, 1, 8'h00);
    cyc(1); expect_head("wrap_00", 8'h00, 1, 8'h01);
    cyc(1); expect_head("wrap_01", 8'h01, 1, 8'h02);

    // Halt drain with two queued entries.
    instr_ready = 1'b0;
    cyc(1);
    expect_head("two", 8'h01, 2, 8'h03);
    halt = 1'b1; instr_ready = 1'b1;
    cyc(1); expect_head("drain1", 8'h02, 1, 8'h03);
    cyc(1); expect_empty("drain2", 8'h03);
    cyc(2); expect_empty("frozen", 8'h03);
    halt = 1'b0;
    cyc(1); expect_head("resume", 8'h03, 1, 8'h04);

    // Redirect while halted loads fetch PC without pushing.
    halt = 1'b1; redirect = 1'b1; redirect_pc = 8'h80;
    cyc(1); expect_empty("halt_redir", 8'h80);
    redirect = 1'b0;
    cyc(1); expect_empty("halt_hold", 8'h80);
    halt = 1'b0; instr_ready = 1'b0;
    cyc(1); expect_head("halt_resume", 8'h80, 1, 8'h81);

    // Async reset mid-cycle with the FIFO full.
    cyc(3);
    expect_head("full", 8'h80, 4, 8'h84);
    #2 reset = 1'b0;
    #1;
    expect_empty("async_rst", 8'h00);
    check("async_rom_addr", 32'(rom_addr), 32'd0);
    check("async_data", 32'(instr_data), 32'd0);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    expect_head("post_rst", 8'h00, 1, 8'h01);

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
